// File: rtl/dds_pkg.sv
// Shared constants for the DDS note synthesizer:
// clock/width parameters, waveform codes and the top-octave increment table.
package dds_pkg;

  localparam int F_CLK_HZ = 50_000_000;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 8;

  localparam logic [2:0] FORM_SAW_UP  = 3'b000;
  localparam logic [2:0] FORM_SAW_DN  = 3'b001;
  localparam logic [2:0] FORM_SQUARE  = 3'b010;
  localparam logic [2:0] FORM_TRI     = 3'b011;
  localparam logic [2:0] FORM_PULSE25 = 3'b100;

  // Increments for MIDI notes 120..131 at 50 MHz.
  // Lower octaves are derived by right shifts.
  localparam logic [ACC_W-1:0] TABLE [0:11] = '{
    32'd719_151,
    32'd761_914,
    32'd807_220,
    32'd855_219,
    32'd906_073,
    32'd959_951,
    32'd1_017_033,
    32'd1_077_509,
    32'd1_141_581,
    32'd1_209_463,
    32'd1_281_381,
    32'd1_357_576
  };

endpackage

// File: rtl/dds_note_synth_note_to_inc.sv
// Note number to phase increment: clamp, octave/semitone decode, shift.
// Ports: CLK, RESET (async low), NOTE in; ADDER registered increment out.
module note_to_inc
  import dds_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       NOTE,
  output logic [ACC_W-1:0] ADDER
);

  logic [6:0]       note_c;
  logic [6:0]       base;
  logic [3:0]       oct;
  logic [3:0]       semi;
  logic [3:0]       shift;
  logic [ACC_W-1:0] inc_nxt;

  assign note_c = NOTE[7] ? 7'd127 : NOTE[6:0];

  // Octave is the count of 12-note thresholds crossed.
  always_comb begin
    oct  = 4'd0;
    base = 7'd0;
    for (int i = 1; i <= 10; i++) begin
      if (note_c >= 7'(12 * i)) begin
        oct  = 4'(i);
        base = 7'(12 * i);
      end
    end
  end

  always_comb begin
    semi    = 4'(note_c - base);
    shift   = 4'd10 - oct;
    inc_nxt = TABLE[semi] >> shift;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ADDER <= '0;
    end else begin
      ADDER <= inc_nxt;
    end
  end

endmodule

// File: rtl/dds_note_synth.sv
// MIDI-note DDS tone generator: increment, phase accumulator, waveform.
// Ports: CLK, RESET, NOTE, FORM in; ADDER, DDS, WAVE, COUNT_DOWN out.
module dds_note_synth
  import dds_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [7:0]       NOTE,
  input  logic [2:0]       FORM,
  output logic [ACC_W-1:0] ADDER,
  output logic [ACC_W-1:0] DDS,
  output logic [OUT_W-1:0] WAVE,
  output logic             COUNT_DOWN
);

  logic [OUT_W-1:0] p;
  logic [OUT_W-1:0] tri_v;
  logic             msb;
  logic [OUT_W-1:0] wave_nxt;

  note_to_inc u_inc (
    .CLK   (CLK),
    .RESET (RESET),
    .NOTE  (NOTE),
    .ADDER (ADDER)
  );

  // Wraps modulo 2^ACC_W; phase is never cleared on note change.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DDS <= '0;
    end else begin
      DDS <= DDS + ADDER;
    end
  end

  assign p     = DDS[ACC_W-1 -: OUT_W];
  assign msb   = DDS[ACC_W-1];
  assign tri_v = DDS[ACC_W-2 -: OUT_W];

  always_comb begin
    wave_nxt = '0;
    unique case (1'b1)
      (FORM == FORM_SAW_UP):  wave_nxt = p;
      (FORM == FORM_SAW_DN):  wave_nxt = ~p;
      (FORM == FORM_SQUARE):  wave_nxt = {OUT_W{~msb}};
      (FORM == FORM_TRI):     wave_nxt = msb ? ~tri_v : tri_v;
      (FORM == FORM_PULSE25):
        wave_nxt = (DDS[ACC_W-1 -: 2] == 2'b00) ? '1 : '0;
      default:                wave_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WAVE       <= '0;
      COUNT_DOWN <= 1'b0;
    end else begin
      WAVE       <= wave_nxt;
      COUNT_DOWN <= msb;
    end
  end

endmodule

// File: tb/tb_dds_note_synth.sv
// Self-checking bench for dds_note_synth against a cycle reference model.
// Directed phases plus randomized note/form segments.
module tb_dds_note_synth;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  NOTE;
  logic [2:0]  FORM;
  logic [31:0] ADDER;
  logic [31:0] DDS;
  logic [7:0]  WAVE;
  logic        COUNT_DOWN;

  dds_note_synth dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .NOTE       (NOTE),
    .FORM       (FORM),
    .ADDER      (ADDER),
    .DDS        (DDS),
    .WAVE       (WAVE),
    .COUNT_DOWN (COUNT_DOWN)
  );

  always #10 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  int          golden [12];
  logic [31:0] m_adder;
  logic [31:0] m_dds;
  logic [7:0]  m_wave;
  logic        m_cd;

  function automatic logic [31:0] inc_of(input int n);
    int nn;
    nn = (n > 127) ? 127 : n;
    return 32'(golden[nn % 12]) >> (10 - nn / 12);
  endfunction

  function automatic logic [7:0] wave_of(input logic [31:0] ph,
                                         input logic [2:0] f);
    longint unsigned x;
    int t;
    x = ph;
    t = int'((x >> 23) % 256);
    case (f)
      3'd0: return 8'(x >> 24);
      3'd1: return 8'(255 - (x >> 24));
      3'd2: return (x < 64'h8000_0000) ? 8'd255 : 8'd0;
      3'd3: return (x < 64'h8000_0000) ? 8'(t) : 8'(255 - t);
      3'd4: return (x < 64'h4000_0000) ? 8'd255 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_adder"}, ADDER, m_adder);
    chk({tag, "_dds"}, DDS, m_dds);
    chk({tag, "_wave"}, 32'(WAVE), 32'(m_wave));
    chk({tag, "_cd"}, 32'(COUNT_DOWN), 32'(m_cd));
  endtask

  task automatic step(input string tag);
    if (!RESET) begin
      m_adder = '0;
      m_dds   = '0;
      m_wave  = '0;
      m_cd    = 1'b0;
    end else begin
      m_wave  = wave_of(m_dds, FORM);
      m_cd    = m_dds[31];
      m_dds   = m_dds + m_adder;
      m_adder = inc_of(int'(NOTE));
    end
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  logic [31:0] a69, a81, a127, d0, d1, d2, prev;
  int          hi, cdh, mx, found;

  initial begin
    for (int s = 0; s < 12; s++) begin
      real f;
      f = 440.0 * $pow(2.0, real'(120 + s - 69) / 12.0);
      golden[s] = $rtoi(f * 4294967296.0 / 50.0e6 + 0.5);
    end
    m_adder = '0; m_dds = '0; m_wave = '0; m_cd = 1'b0;
    RESET = 1'b0; NOTE = 8'd69; FORM = 3'd0;

    // Reset hold
    for (int i = 0; i < 5; i++) step("rst");
    #5 RESET = 1'b1;
    step("rel1");
    chk("rel1_adder_val", ADDER, 32'd37_795);
    step("rel2");
    chk("rel2_dds_val", DDS, 32'd37_795);
    step("rel3");
    chk("rel3_dds_val", DDS, 32'd75_590);

    // Table sweep
    for (int n = 0; n < 128; n++) begin
      NOTE = 8'(n);
      step("sweep");
      if (n == 69)  a69  = ADDER;
      if (n == 81)  a81  = ADDER;
      if (n == 127) a127 = ADDER;
    end
    NOTE = 8'd129; step("n129");
    chk("n129_eq_127", ADDER, a127);
    NOTE = 8'd255; step("n255");
    chk("n81_double", 32'((a81 + 1 >= 2 * a69) && (a81 <= 2 * a69 + 1)), 32'd1);

    // Wrap
    NOTE = 8'd127; FORM = 3'd0;
    found = 0;
    for (int i = 0; i < 10000 && found == 0; i++) begin
      prev = DDS;
      step("wrap_run");
      if (DDS < prev) found = 1;
    end
    chk("wrap_seen", 32'(found), 32'd1);
    chk("wrap_cd_before", 32'(COUNT_DOWN), 32'd1);
    step("wrap_after");
    chk("wrap_wave_small", 32'(WAVE < 8'd8), 32'd1);
    chk("wrap_cd_after", 32'(COUNT_DOWN), 32'd0);

    // Forms over one period at NOTE=127 (~3986 CLK)
    for (int f = 0; f < 8; f++) begin
      FORM = 3'(f);
      step("form_first");
      hi = 0; cdh = 0; mx = 0;
      for (int i = 0; i < 3986; i++) begin
        step("form");
        if (WAVE == 8'hFF) hi++;
        if (COUNT_DOWN) cdh++;
        if (int'(WAVE) > mx) mx = int'(WAVE);
      end
      if (f == 2) chk("square_duty", 32'(hi >= 1973 && hi <= 2013), 32'd1);
      if (f == 3) begin
        chk("tri_peak", 32'(mx), 32'd255);
        chk("tri_cd_half", 32'(cdh >= 1973 && cdh <= 2013), 32'd1);
      end
      if (f == 4) chk("pulse_duty", 32'(hi >= 976 && hi <= 1016), 32'd1);
      if (f >= 5) chk("muted_max", 32'(mx), 32'd0);
    end

    // Note change 69 -> 81
    NOTE = 8'd69; FORM = 3'd3;
    for (int i = 0; i < 4; i++) step("nc_pre");
    d0 = DDS;
    NOTE = 8'd81;
    step("nc1"); d1 = DDS;
    step("nc2"); d2 = DDS;
    chk("nc_slope_old", d1 - d0, 32'd37_795);
    chk("nc_slope_new", d2 - d1, 32'd75_591);

    // Async reset mid-run
    for (int i = 0; i < 10; i++) step("ar_pre");
    #3 RESET = 1'b0;
    #1;
    m_adder = '0; m_dds = '0; m_wave = '0; m_cd = 1'b0;
    check_all("async_rst");
    step("async_hold");
    #4 RESET = 1'b1;
    step("async_rel");

    // Randomized segments
    for (int k = 0; k < 20; k++) begin
      int len;
      NOTE = 8'($urandom_range(0, 255));
      FORM = 3'($urandom_range(0, 7));
      len = int'($urandom_range(5, 200));
      for (int i = 0; i < len; i++) step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
